hmac_multimode_core: RTL and testbench
======================================

HMAC_MULTIMODE_CORE -- requirements
Module: hmac_multimode_core

Interface
REQ-001 SHALL have parameter LFSR_W, default 32, meaning the width of each entropy LFSR; 384 SHALL be divisible by LFSR_W, otherwise elaboration fails.
REQ-002 SHALL have parameter NUM_LFSR, default 384/LFSR_W, meaning the LFSR instance count; it is derived and SHALL NOT be overridden.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk input 1, clock; reset_n input 1, async active-low reset.
REQ-004 zeroize input 1: synchronous clear of all state.
REQ-005 init_cmd input 1: start a keyed operation on the first block.
REQ-006 next_cmd input 1: process a further block using the latched key and mode.
REQ-007 mode input 1: 0 = HMAC-384, 1 = HMAC-512; sampled only on an accepted init_cmd.
REQ-008 lfsr_seed input 384: LFSR seeds.
REQ-009 key input 512: key, MSB-aligned.
REQ-010 block_msg input 1024: message block.
REQ-011 ready output 1: high when in IDLE.
REQ-012 tag_valid output 1: tag is valid.
REQ-013 tag output 512: MSB-aligned tag; tag[127:0] is 0 in HMAC-384 mode.
REQ-014 cmd_err output 1: one-cycle pulse when a command is rejected.

Function
REQ-015 SHALL instantiate two sha512_masked_core instances, H1 (inner) and H2 (outer); each receives 192 bits of entropy (H1 gets [191:0], H2 gets [383:192]).
REQ-016 Core mode SHALL be 2'h2 when latched mode is 0 and 2'h3 when it is 1.
REQ-017 In HMAC-384 mode, key[127:0] SHALL be forced to zero before padding.
REQ-018 Padded keys SHALL be key_ipad = {key,512'b0} ^ 0x36 repeated and key_opad = {key,512'b0} ^ 0x5c repeated.
REQ-019 The final block SHALL be built as follows:
- HMAC-384: {H1_digest[511:128], 1'b1, zeros, 128'h580}.
- HMAC-512: {H1_digest, 1'b1, zeros, 128'h600}.
REQ-020 The FSM SHALL have states IDLE, IPAD, OPAD, HMAC and DONE, with one-hot or binary encoding.
REQ-021 IDLE transitions:
- init_cmd: go to IPAD, set keyed_reg to 1 and latch mode.
- next_cmd with keyed_reg = 1: go to OPAD.
- next_cmd with keyed_reg = 0: stay in IDLE and pulse cmd_err.
REQ-022 If init_cmd and next_cmd are both high in IDLE, init_cmd SHALL win.
REQ-023 On state entry (current state differs from the registered previous state), the FSM SHALL issue one-cycle strobes:
- IPAD: H1 init on key_ipad.
- OPAD: H1 next on block_msg, and H2 init on key_opad.
- HMAC: H2 next on the final block.
REQ-024 IPAD SHALL advance when H1 is ready, OPAD when H1 and H2 are both ready, and HMAC when H2 is ready; the ready check SHALL be masked low on the entry cycle.
REQ-025 DONE SHALL set tag_valid in the next cycle and return to IDLE unconditionally, one cycle after HMAC.
REQ-026 tag_valid SHALL clear on the cycle after an accepted init_cmd or next_cmd, and otherwise hold.
REQ-027 An init_cmd or next_cmd arriving outside IDLE SHALL be ignored, pulse cmd_err for one cycle, and leave the in-progress operation unaffected.
REQ-028 The LFSRs SHALL be enabled by an accepted init_cmd only.
REQ-029 zeroize SHALL return the block to IDLE, clear keyed_reg, tag_valid, cmd_err and the latched key and mode in the next cycle, and propagate to both cores and all LFSRs.

Reset
REQ-030 On reset_n low, the FSM and previous-state register SHALL be IDLE, and ready SHALL read 1 after reset deasserts.
REQ-031 On reset_n low, the following SHALL be 0: tag_valid, cmd_err, keyed_reg, the latched mode and key, and tag.
REQ-032 Reset asserted mid-operation SHALL abort immediately, and a subsequent next_cmd SHALL be rejected.

Configuration
REQ-033 With HMAC_KEY_LATCH_EN defined, key SHALL be captured into a 512-bit register on an accepted init_cmd and used for all later blocks; the key input MAY change afterwards.
REQ-034 Without HMAC_KEY_LATCH_EN, the key SHALL be used directly from the port, and the integrator SHALL hold it stable from init_cmd until the final tag_valid.

Structure
REQ-035 The shared package hmac_multimode_pkg SHALL hold the state enum, IPAD and OPAD constants, both length constants (0x580, 0x600), and the mode encodings.
REQ-036 The NUM_LFSR instances SHALL be the existing sub-module hmac_lfsr, with REG_SIZE set to LFSR_W.

Verification
REQ-037 Scenario, RFC 4231 TC1 in HMAC-384:
- Stimulus: key = 0x0b repeated 20 bytes (MSB-aligned); block = "Hi There", 0x80 padding and length 0x440; init_cmd with mode 0.
- Required response: tag[511:128] = afd03944d84895626b0825f4ab46907f15f9dadbe4101ec682aa034c7cebc59cfaea9ea9076ede7f4af152e8b2fa9cb6, and tag[127:0] = 0.
REQ-038 Scenario, RFC 4231 TC1 in HMAC-512 (same stimulus, mode 1):
- Required response: tag = 87aa7cdea5ef619d4ff0b4241a1d6cb02379f4e2ce4ec2787ad0b30545e17cdedaa833b7d6b8a702038b274eaea3f4e4be9d914eeb61f1702e696c203a126854.
REQ-039 Scenario, next_cmd after reset with no prior init:
- Required response: cmd_err is a one-cycle pulse, ready stays 1, and tag_valid stays 0.
REQ-040 Scenario, init_cmd pulsed while in OPAD:
- Required response: cmd_err pulses and the final tag equals the undisturbed TC1 result.
REQ-041 Scenario, zeroize asserted while in HMAC:
- Required response: the next cycle shows IDLE with tag_valid = 0, and a subsequent next_cmd is rejected with cmd_err.
REQ-042 Scenario, init_cmd and next_cmd asserted together in IDLE:
- Required response: IPAD is entered (H1 init strobe seen) and the latched mode equals the mode input.

Source files
------------

// File: rtl/hmac_multimode_pkg.sv
// Shared types and constants for the HMAC-384/512 wrapper: FSM states, pad patterns,
// outer-block length fields and mode encodings.
package hmac_multimode_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      IPAD = 3'd1,
      OPAD = 3'd2,
      HMAC = 3'd3,
      DONE = 3'd4
   } hmac_state_t;

   localparam logic [1023:0] IPAD_PAT = {128{8'h36}};
   localparam logic [1023:0] OPAD_PAT = {128{8'h5c}};

   // Bit lengths of (128-byte padded key + inner digest) for the outer hash
   localparam logic [127:0] LEN_384 = 128'h580;
   localparam logic [127:0] LEN_512 = 128'h600;

   localparam logic       MODE_HMAC384  = 1'b0;
   localparam logic       MODE_HMAC512  = 1'b1;
   localparam logic [1:0] CORE_MODE_384 = 2'h2;
   localparam logic [1:0] CORE_MODE_512 = 2'h3;

endpackage

// File: rtl/hmac_lfsr.sv
// Entropy LFSR: one step per enable pulse, reseeded by XOR with the seed input.
// Latency: output updates the cycle after en. No backpressure.
// Backpressure: none; en is a single-cycle strobe.
module hmac_lfsr #(
   parameter int REG_SIZE = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                zeroize,
   input  logic                en,
   input  logic [REG_SIZE-1:0] seed,
   output logic [REG_SIZE-1:0] rnd
);

   logic [REG_SIZE-1:0] lfsr_q;
   logic                fb;

   assign fb  = lfsr_q[REG_SIZE-1] ^ lfsr_q[REG_SIZE-2] ^ lfsr_q[REG_SIZE-3] ^ lfsr_q[0];
   assign rnd = lfsr_q;

   // Folding the seed in on every step keeps an all-zero state from locking up
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_q <= '0;
      end else if (zeroize) begin
         lfsr_q <= '0;
      end else if (en) begin
         lfsr_q <= {lfsr_q[REG_SIZE-2:0], fb} ^ seed;
      end
   end

endmodule

// File: rtl/sha512_masked_core.sv
// SHA-384/512 block engine, one round per cycle, message schedule stored under an entropy mask.
// Latency: 80 cycles per block after the accepted init/next strobe.
// Backpressure: strobes are only accepted while ready is high; others are dropped.
module sha512_masked_core (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          zeroize,
   input  logic          init_cmd,
   input  logic          next_cmd,
   input  logic [1:0]    mode,
   input  logic [1023:0] block_msg,
   input  logic [191:0]  entropy,
   output logic          ready,
   output logic [511:0]  digest
);

   localparam logic [0:79][63:0] K = {
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // SHA-512/t variants are not used by the HMAC wrapper and fall back to the SHA-512 IV
   function automatic logic [0:7][63:0] iv(input logic [1:0] m);
      if (m == 2'h2)
         return {64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
                 64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
      return {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
              64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
   endfunction

   logic              busy;
   logic [6:0]        round;
   logic [0:7][63:0]  h_q, wv_q, wv_nxt, h_sum, h_base;
   logic [0:15][63:0] w_q;
   logic [63:0]       mask_q, mask_new, w_cur, w_new, t1, t2;

   assign ready    = ~busy;
   assign digest   = h_q;
   assign mask_new = entropy[63:0] ^ entropy[127:64] ^ entropy[191:128];

   always_comb begin
      w_cur  = w_q[0] ^ mask_q;
      t1     = wv_q[7] + (rotr(wv_q[4], 14) ^ rotr(wv_q[4], 18) ^ rotr(wv_q[4], 41))
             + ((wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6])) + K[round] + w_cur;
      t2     = (rotr(wv_q[0], 28) ^ rotr(wv_q[0], 34) ^ rotr(wv_q[0], 39))
             + ((wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]));
      wv_nxt = {t1 + t2, wv_q[0], wv_q[1], wv_q[2], wv_q[3] + t1, wv_q[4], wv_q[5], wv_q[6]};
      w_new  = (rotr(w_q[14] ^ mask_q, 19) ^ rotr(w_q[14] ^ mask_q, 61) ^ ((w_q[14] ^ mask_q) >> 6))
             + (w_q[9] ^ mask_q)
             + (rotr(w_q[1] ^ mask_q, 1) ^ rotr(w_q[1] ^ mask_q, 8) ^ ((w_q[1] ^ mask_q) >> 7))
             + w_cur;
      h_sum  = '0;
      for (int i = 0; i < 8; i++) h_sum[i] = h_q[i] + wv_nxt[i];
      h_base = init_cmd ? iv(mode) : h_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy   <= 1'b0;
         round  <= '0;
         h_q    <= '0;
         wv_q   <= '0;
         w_q    <= '0;
         mask_q <= '0;
      end else if (zeroize) begin
         busy   <= 1'b0;
         round  <= '0;
         h_q    <= '0;
         wv_q   <= '0;
         w_q    <= '0;
         mask_q <= '0;
      end else if (!busy && (init_cmd || next_cmd)) begin
         busy   <= 1'b1;
         round  <= '0;
         h_q    <= h_base;
         wv_q   <= h_base;
         mask_q <= mask_new;
         w_q    <= block_msg ^ {16{mask_new}};
      end else if (busy) begin
         wv_q <= wv_nxt;
         w_q  <= {w_q[1:15], w_new ^ mask_q};
         if (round == 7'd79) begin
            busy  <= 1'b0;
            round <= '0;
            h_q   <= h_sum;
         end else begin
            round <= round + 7'd1;
         end
      end
   end

endmodule

// File: rtl/hmac_multimode_core.sv
// HMAC-384/512 over two SHA-512 cores (inner H1, outer H2); optional key latch via HMAC_KEY_LATCH_EN.
// Latency: ~3 core blocks plus 2 cycles from init_cmd to tag_valid; ~2 blocks from next_cmd.
// Backpressure: commands only accepted while ready; others are dropped with a cmd_err pulse.
module hmac_multimode_core
   import hmac_multimode_pkg::*;
#(
   parameter int LFSR_W   = 32,
   parameter int NUM_LFSR = 384 / LFSR_W
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          zeroize,
   input  logic          init_cmd,
   input  logic          next_cmd,
   input  logic          mode,
   input  logic [383:0]  lfsr_seed,
   input  logic [511:0]  key,
   input  logic [1023:0] block_msg,
   output logic          ready,
   output logic          tag_valid,
   output logic [511:0]  tag,
   output logic          cmd_err
);

   if ((384 % LFSR_W) != 0 || (NUM_LFSR * LFSR_W) != 384) begin : g_bad_lfsr_w
      $error("LFSR_W must divide 384 and NUM_LFSR must equal 384/LFSR_W");
   end

   hmac_state_t   state, state_nxt, prev_state;
   logic          keyed_reg, mode_reg;
   logic          entry, init_acc, next_acc, cmd_rej;
   logic          h1_init, h1_next, h2_init, h2_next, h1_rdy, h2_rdy;
   logic [511:0]  h1_digest, h2_digest, key_src, key_mode;
   logic [1023:0] key_ipad, key_opad, final_block, h1_block, h2_block;
   logic [383:0]  entropy;
   logic [1:0]    core_mode;

`ifdef HMAC_KEY_LATCH_EN
   logic [511:0] key_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      key_reg <= '0;
      else if (zeroize)  key_reg <= '0;
      else if (init_acc) key_reg <= key;
   end

   assign key_src = key_reg;
`else
   assign key_src = key;
`endif

   assign ready     = (state == IDLE);
   assign entry     = (state != prev_state);
   assign core_mode = (mode_reg == MODE_HMAC512) ? CORE_MODE_512 : CORE_MODE_384;
   assign key_mode  = (mode_reg == MODE_HMAC512) ? key_src : {key_src[511:128], 128'b0};
   assign key_ipad  = {key_mode, 512'b0} ^ IPAD_PAT;
   assign key_opad  = {key_mode, 512'b0} ^ OPAD_PAT;
   assign final_block = (mode_reg == MODE_HMAC512) ? {h1_digest, 1'b1, 383'b0, LEN_512}
                                                   : {h1_digest[511:128], 1'b1, 511'b0, LEN_384};
   assign h1_block  = h1_init ? key_ipad : block_msg;
   assign h2_block  = h2_init ? key_opad : final_block;

   // Strobes fire only on the first cycle of a state; the core's ready is stale that cycle
   always_comb begin
      state_nxt = state;
      init_acc  = 1'b0;
      next_acc  = 1'b0;
      cmd_rej   = 1'b0;
      h1_init   = 1'b0;
      h1_next   = 1'b0;
      h2_init   = 1'b0;
      h2_next   = 1'b0;
      case (state)
         IDLE: begin
            if (init_cmd) begin
               init_acc  = 1'b1;
               state_nxt = IPAD;
            end else if (next_cmd) begin
               if (keyed_reg) begin
                  next_acc  = 1'b1;
                  state_nxt = OPAD;
               end else begin
                  cmd_rej = 1'b1;
               end
            end
         end
         IPAD: begin
            h1_init = entry;
            if (!entry && h1_rdy) state_nxt = OPAD;
         end
         OPAD: begin
            h1_next = entry;
            h2_init = entry;
            if (!entry && h1_rdy && h2_rdy) state_nxt = HMAC;
         end
         HMAC: begin
            h2_next = entry;
            if (!entry && h2_rdy) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (state != IDLE && (init_cmd || next_cmd)) cmd_rej = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         prev_state <= IDLE;
         keyed_reg  <= 1'b0;
         mode_reg   <= 1'b0;
         tag_valid  <= 1'b0;
         tag        <= '0;
         cmd_err    <= 1'b0;
      end else if (zeroize) begin
         state      <= IDLE;
         prev_state <= IDLE;
         keyed_reg  <= 1'b0;
         mode_reg   <= 1'b0;
         tag_valid  <= 1'b0;
         tag        <= '0;
         cmd_err    <= 1'b0;
      end else begin
         state      <= state_nxt;
         prev_state <= state;
         cmd_err    <= cmd_rej;
         if (init_acc) begin
            keyed_reg <= 1'b1;
            mode_reg  <= mode;
         end
         if (init_acc || next_acc) begin
            tag_valid <= 1'b0;
         end else if (state == DONE) begin
            tag_valid <= 1'b1;
            tag       <= (mode_reg == MODE_HMAC512) ? h2_digest : {h2_digest[511:128], 128'b0};
         end
      end
   end

   for (genvar i = 0; i < NUM_LFSR; i++) begin : g_lfsr
      hmac_lfsr #(.REG_SIZE(LFSR_W)) u_lfsr (
         .clk     (clk),
         .reset_n (reset_n),
         .zeroize (zeroize),
         .en      (init_acc),
         .seed    (lfsr_seed[i*LFSR_W +: LFSR_W]),
         .rnd     (entropy[i*LFSR_W +: LFSR_W])
      );
   end

   sha512_masked_core u_h1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .zeroize   (zeroize),
      .init_cmd  (h1_init),
      .next_cmd  (h1_next),
      .mode      (core_mode),
      .block_msg (h1_block),
      .entropy   (entropy[191:0]),
      .ready     (h1_rdy),
      .digest    (h1_digest)
   );

   sha512_masked_core u_h2 (
      .clk       (clk),
      .reset_n   (reset_n),
      .zeroize   (zeroize),
      .init_cmd  (h2_init),
      .next_cmd  (h2_next),
      .mode      (core_mode),
      .block_msg (h2_block),
      .entropy   (entropy[383:192]),
      .ready     (h2_rdy),
      .digest    (h2_digest)
   );

endmodule

// File: tb/tb_hmac_multimode_core.sv
// Bench for hmac_multimode_core: RFC 4231 vector table plus command-protocol corner cases.
module tb_hmac_multimode_core;
   import hmac_multimode_pkg::*;

   logic          clk = 1'b0;
   logic          reset_n, zeroize, init_cmd, next_cmd, mode;
   logic [383:0]  lfsr_seed;
   logic [511:0]  key;
   logic [1023:0] block_msg;
   logic          ready, tag_valid, cmd_err;
   logic [511:0]  tag;

   always #5 clk = ~clk;

   hmac_multimode_core dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .zeroize   (zeroize),
      .init_cmd  (init_cmd),
      .next_cmd  (next_cmd),
      .mode      (mode),
      .lfsr_seed (lfsr_seed),
      .key       (key),
      .block_msg (block_msg),
      .ready     (ready),
      .tag_valid (tag_valid),
      .tag       (tag),
      .cmd_err   (cmd_err)
   );

   typedef struct packed {
      logic          mode;
      logic [511:0]  key;
      logic [1023:0] blk;
      logic [511:0]  exp_tag;
   } vec_t;

   vec_t         vecs [4];
   logic [511:0] exp_q [$];
   int           n_tests = 0;
   int           n_fail  = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [1023:0] mk_block(input string msg);
      logic [1023:0] b;
      int            n;
      b = '0;
      n = msg.len();
      for (int i = 0; i < n; i++) b[1023-8*i -: 8] = msg.getc(i);
      b[1023-8*n -: 8] = 8'h80;
      b[127:0] = 128'((128 + n) * 8);
      return b;
   endfunction

   task automatic start_init(input logic m, input logic [511:0] k, input logic [1023:0] b,
                             input logic push, input logic [511:0] e);
      mode      = m;
      key       = k;
      block_msg = b;
      init_cmd  = 1'b1;
      if (push) exp_q.push_back(e);
      @(negedge clk);
      init_cmd = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int cyc = 0;
      while (tag_valid !== 1'b1 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_tag_valid"}, tag_valid, 1'b1);
   endtask

   task automatic wait_tag(input string name);
      logic [511:0] e;
      wait_valid(name);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check({name, "_tag"}, tag, e);
   endtask

   task automatic wait_state(input hmac_state_t s, input string name);
      int cyc = 0;
      while (dut.state != s && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_reach_state"}, dut.state == s, 1'b1);
   endtask

   task automatic pulse_next();
      next_cmd = 1'b1;
      @(negedge clk);
      next_cmd = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [511:0]  k1, k2, t1_384, t1_512, t2_384, t2_512;
      logic [1023:0] b1, b2;

      reset_n = 1'b0; zeroize = 1'b0; init_cmd = 1'b0; next_cmd = 1'b0; mode = 1'b0;
      key = '0; block_msg = '0;
      for (int i = 0; i < 12; i++) lfsr_seed[32*i +: 32] = $urandom;

      k1 = {{20{8'h0b}}, 352'b0};
      k2 = {32'h4a656665, 480'b0};
      b1 = mk_block("Hi There");
      b2 = mk_block("what do ya want for nothing?");
      t1_384 = {384'hafd03944d84895626b0825f4ab46907f15f9dadbe4101ec682aa034c7cebc59cfaea9ea9076ede7f4af152e8b2fa9cb6, 128'b0};
      t1_512 = 512'h87aa7cdea5ef619d4ff0b4241a1d6cb02379f4e2ce4ec2787ad0b30545e17cdedaa833b7d6b8a702038b274eaea3f4e4be9d914eeb61f1702e696c203a126854;
      t2_384 = {384'haf45d2e376484031617f78d2b58a6b1b9c7ef464f5a01b47e42ec3736322445e8e2240ca5e69e2c78b3239ecfab21649, 128'b0};
      t2_512 = 512'h164b7a7bfcf819e2e395fbe73b56e0a387bd64222e831fd610270cd7ea2505549758bf75c05a994a6d034f65f8f0e6fdcaeab1a34d4a6b4b636e070a38bce737;
      vecs[0] = '{mode: 1'b0, key: k1, blk: b1, exp_tag: t1_384};
      vecs[1] = '{mode: 1'b1, key: k1, blk: b1, exp_tag: t1_512};
      vecs[2] = '{mode: 1'b0, key: k2, blk: b2, exp_tag: t2_384};
      vecs[3] = '{mode: 1'b1, key: k2, blk: b2, exp_tag: t2_512};

      repeat (3) @(negedge clk);
      check("rst_ready", ready, 1'b1);
      check("rst_tag_valid", tag_valid, 1'b0);
      check("rst_cmd_err", cmd_err, 1'b0);
      check("rst_tag", tag, '0);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", ready, 1'b1);

      // next_cmd with no key loaded
      pulse_next();
      check("nokey_cmd_err", cmd_err, 1'b1);
      check("nokey_ready", ready, 1'b1);
      @(negedge clk);
      check("nokey_cmd_err_clear", cmd_err, 1'b0);
      check("nokey_tag_valid", tag_valid, 1'b0);

      for (int i = 0; i < 4; i++) begin
         start_init(vecs[i].mode, vecs[i].key, vecs[i].blk, 1'b1, vecs[i].exp_tag);
         check($sformatf("vec%0d_tv_clear", i), tag_valid, 1'b0);
         check($sformatf("vec%0d_busy", i), ready, 1'b0);
         wait_tag($sformatf("vec%0d", i));
         check($sformatf("vec%0d_no_err", i), cmd_err, 1'b0);
      end

      // keyed next_cmd is accepted and produces a new tag
      pulse_next();
      check("next_acc_err", cmd_err, 1'b0);
      check("next_acc_busy", ready, 1'b0);
      check("next_acc_tv_clear", tag_valid, 1'b0);
      wait_valid("next_acc");

      // init_cmd while in OPAD is ignored
      start_init(1'b0, k1, b1, 1'b1, t1_384);
      wait_state(OPAD, "opad_init");
      mode = 1'b1;
      init_cmd = 1'b1;
      @(negedge clk);
      init_cmd = 1'b0;
      check("opad_init_cmd_err", cmd_err, 1'b1);
      check("opad_init_mode_kept", dut.mode_reg, 1'b0);
      @(negedge clk);
      check("opad_init_err_clear", cmd_err, 1'b0);
      wait_tag("opad_init");

      // zeroize during HMAC
      start_init(1'b1, k1, b1, 1'b0, '0);
      wait_state(HMAC, "zeroize");
      zeroize = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
      check("zeroize_ready", ready, 1'b1);
      check("zeroize_tag_valid", tag_valid, 1'b0);
      check("zeroize_tag", tag, '0);
      pulse_next();
      check("zeroize_next_err", cmd_err, 1'b1);
      check("zeroize_next_ready", ready, 1'b1);

      // init_cmd and next_cmd together in IDLE
      @(negedge clk);
      mode = 1'b1; key = k1; block_msg = b1;
      init_cmd = 1'b1; next_cmd = 1'b1;
      exp_q.push_back(t1_512);
      @(negedge clk);
      init_cmd = 1'b0; next_cmd = 1'b0;
      check("both_h1_init", dut.h1_init, 1'b1);
      check("both_mode_reg", dut.mode_reg, 1'b1);
      check("both_state", dut.state == IPAD, 1'b1);
      check("both_no_err", cmd_err, 1'b0);
      wait_tag("both");

      // reset mid-operation
      start_init(1'b0, k2, b2, 1'b0, '0);
      repeat (50) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midrst_ready", ready, 1'b1);
      check("midrst_tag_valid", tag_valid, 1'b0);
      check("midrst_tag", tag, '0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      pulse_next();
      check("midrst_next_err", cmd_err, 1'b1);
      check("midrst_next_ready", ready, 1'b1);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
